core_wb_bridge: RTL

Parametrised multi-channel bridge from the core's native memory ports to Wishbone B4 master ports. It sits between the CPU and the Controller's instruction and data memories, and replaces hard-wired `cyc`/`stb` ties and fixed address arithmetic with a real per-channel handshake FSM. It supports classic or pipelined Wishbone, a configurable address offset and shift, error reporting, and a bus timeout.

---
 rtl/core_wb_bridge_pkg.sv | 20 ++
 rtl/wb_master_channel.sv | 163 ++++++++++++++++
 rtl/core_wb_bridge.sv | 78 +++++++
 3 files changed

// File: rtl/core_wb_bridge_pkg.sv
// Shared definitions for the core-to-Wishbone bridge.
//   ch_state_e      : per-channel handshake FSM encoding
//   TIMEOUT_DISABLE : TIMEOUT value that turns the bus timeout off
//   tmo_width()     : timeout counter width (at least 1 bit)
package core_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } ch_state_e;

    localparam int TIMEOUT_DISABLE = 0;

    function automatic int tmo_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_master_channel.sv
// One Wishbone B4 master channel: request latch, handshake FSM, timeout
// counter and single-cycle response generation.
// Ports:
//   sys_clk, rst_n                      clock, async active-low reset
//   req_valid/ready/we/sel/addr/wdata   core request side
//   rsp_valid/rdata/err                 one-cycle response pulse
//   wb_*_o                              registered Wishbone master outputs
//   wb_dat_i/ack_i/err_i/stall_i        Wishbone slave returns
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction, ready for a request
// BUS     | cyc and stb asserted, request on the bus
// WAIT    | pipelined only: request taken by slave, cyc held for ack/err
// RESP    | rsp_valid pulse; a new request can be accepted here
module wb_master_channel
    import core_wb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_OFFSET = 0,
    parameter int ADDR_SHIFT  = 2,
    parameter int PIPELINED   = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_sel,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int TMO_W = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    ch_state_e               state_q, state_d;
    logic                    rst_done_q;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    accept;
    logic                    timeout_hit;
    logic [ADDR_WIDTH-1:0]   adr_calc;

    // Wraps modulo 2^ADDR_WIDTH on underflow and on shift overflow.
    assign adr_calc    = (req_addr - ADDR_WIDTH'(ADDR_OFFSET)) << ADDR_SHIFT;

    // The counter holds the number of completed BUS/WAIT cycles, so the
    // TIMEOUT-th bus cycle is the last one.
    assign timeout_hit = (TIMEOUT != TIMEOUT_DISABLE) && (tmo_cnt_q == TMO_LAST);

    // Held low for the first cycle after reset release.
    assign req_ready   = rst_done_q && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    assign accept      = req_ready && req_valid;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        tmo_cnt_d   = tmo_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d   = ST_BUS;
                    we_d      = req_we;
                    sel_d     = req_sel;
                    adr_d     = adr_calc;
                    dat_d     = req_wdata;
                    tmo_cnt_d = '0;
                end
            end
            ST_BUS, ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (wb_ack_i || wb_err_i || timeout_hit) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    // err wins over ack; neither present means timeout
                    rsp_err_d   = wb_err_i || !wb_ack_i;
                    rsp_rdata_d = (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : '0;
                end else if ((state_q == ST_BUS) && (PIPELINED != 0) && !wb_stall_i) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cyc_d = (state_d == ST_BUS) || (state_d == ST_WAIT);
        stb_d = (state_d == ST_BUS);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rst_done_q  <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            tmo_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= 1'b1;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: rtl/core_wb_bridge.sv
// Multi-channel bridge from the core's native memory ports to Wishbone B4
// master ports. Channel 0 is instruction fetch, channel 1 is data; channels
// are fully independent (no arbitration, no cross-channel ordering).
// Ports (all flattened, channel g occupies slice g):
//   sys_clk, rst_n                      clock, async active-low reset
//   req_*                               core requests, req_ready per channel
//   rsp_*                               one-cycle responses, no back-pressure
//   wb_*_o / wb_*_i                     Wishbone master ports
module core_wb_bridge
    import core_wb_bridge_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_OFFSET = 0,
    parameter int ADDR_SHIFT  = 2,
    parameter int PIPELINED   = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    input  logic [N_CH-1:0]                req_valid,
    output logic [N_CH-1:0]                req_ready,
    input  logic [N_CH-1:0]                req_we,
    input  logic [N_CH*(DATA_WIDTH/8)-1:0] req_sel,
    input  logic [N_CH*ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_CH*DATA_WIDTH-1:0]     req_wdata,
    output logic [N_CH-1:0]                rsp_valid,
    output logic [N_CH*DATA_WIDTH-1:0]     rsp_rdata,
    output logic [N_CH-1:0]                rsp_err,
    output logic [N_CH-1:0]                wb_cyc_o,
    output logic [N_CH-1:0]                wb_stb_o,
    output logic [N_CH-1:0]                wb_we_o,
    output logic [N_CH*(DATA_WIDTH/8)-1:0] wb_sel_o,
    output logic [N_CH*ADDR_WIDTH-1:0]     wb_adr_o,
    output logic [N_CH*DATA_WIDTH-1:0]     wb_dat_o,
    input  logic [N_CH*DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [N_CH-1:0]                wb_ack_i,
    input  logic [N_CH-1:0]                wb_err_i,
    input  logic [N_CH-1:0]                wb_stall_i
);

    localparam int SEL_W = DATA_WIDTH / 8;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        wb_master_channel #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_OFFSET (ADDR_OFFSET),
            .ADDR_SHIFT  (ADDR_SHIFT),
            .PIPELINED   (PIPELINED),
            .TIMEOUT     (TIMEOUT)
        ) u_ch (
            .sys_clk    (sys_clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_sel    (req_sel[g*SEL_W +: SEL_W]),
            .req_addr   (req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .req_wdata  (req_wdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .rsp_err    (rsp_err[g]),
            .wb_cyc_o   (wb_cyc_o[g]),
            .wb_stb_o   (wb_stb_o[g]),
            .wb_we_o    (wb_we_o[g]),
            .wb_sel_o   (wb_sel_o[g*SEL_W +: SEL_W]),
            .wb_adr_o   (wb_adr_o[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .wb_dat_o   (wb_dat_o[g*DATA_WIDTH +: DATA_WIDTH]),
            .wb_dat_i   (wb_dat_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .wb_ack_i   (wb_ack_i[g]),
            .wb_err_i   (wb_err_i[g]),
            .wb_stall_i (wb_stall_i[g])
        );
    end

endmodule
